alu_seq_control: RTL and testbench

ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

---
 rtl/alu_seq_control.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_seq_control.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_control.sv
// alu_seq_control: registered ALU control decode plus a mult/div occupancy
// sequencer (IDLE -> RUN -> DONE) that stalls HI/LO and mult/div consumers
// while an operation is in flight and pulses a HI/LO commit when it ends.
// Optional feature macro: ALU_SEQ_MADD_EN (SPECIAL2 MADD/MADDU/MSUB/MSUBU).
module alu_seq_control #(
  parameter int CTRL_W      = 5,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEnable,
  input  logic              iFlush,
  input  logic [1:0]        iALUOp,
  input  logic [5:0]        iOpcode,
  input  logic [5:0]        iFunct,
  input  logic [4:0]        iRt,
  output logic [CTRL_W-1:0] oControlSignal,
  output logic              oIllegal,
  output logic              oMDStart,
  output logic              oMDBusy,
  output logic              oStall,
  output logic              oHiLoWrite
);

  // Shared ALU control codes; 0 is reserved for bubbles / illegal encodings.
  localparam logic [CTRL_W-1:0] OPADD   = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OPADDU  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OPSUB   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OPSUBU  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OPAND   = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OPOR    = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OPXOR   = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OPNOR   = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OPSLT   = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] OPSLTU  = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] OPSLL   = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] OPSRL   = CTRL_W'(12);
  localparam logic [CTRL_W-1:0] OPSRA   = CTRL_W'(13);
  localparam logic [CTRL_W-1:0] OPLUI   = CTRL_W'(14);
  localparam logic [CTRL_W-1:0] OPSGT   = CTRL_W'(15);
  localparam logic [CTRL_W-1:0] OPMFHI  = CTRL_W'(16);
  localparam logic [CTRL_W-1:0] OPMTHI  = CTRL_W'(17);
  localparam logic [CTRL_W-1:0] OPMFLO  = CTRL_W'(18);
  localparam logic [CTRL_W-1:0] OPMTLO  = CTRL_W'(19);
  localparam logic [CTRL_W-1:0] OPMULT  = CTRL_W'(20);
  localparam logic [CTRL_W-1:0] OPMULTU = CTRL_W'(21);
  localparam logic [CTRL_W-1:0] OPDIV   = CTRL_W'(22);
  localparam logic [CTRL_W-1:0] OPDIVU  = CTRL_W'(23);
  localparam logic [CTRL_W-1:0] OPMADD  = CTRL_W'(24);
  localparam logic [CTRL_W-1:0] OPMADDU = CTRL_W'(25);
  localparam logic [CTRL_W-1:0] OPMSUB  = CTRL_W'(26);
  localparam logic [CTRL_W-1:0] OPMSUBU = CTRL_W'(27);

  // Counter preload: RUN lasts exactly `cycles` clocks, counting down to 0.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  seq_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              start_reg, start_next;
  logic              hilo_reg, hilo_next;
  logic [CTRL_W-1:0] ctrl_reg;
  logic              illegal_reg;

  logic [CTRL_W-1:0] dec_code;
  logic              dec_illegal;
  logic              dec_md;
  logic              dec_hl;
  logic              dec_div;
  logic              stall;
  logic              accept;

  // Combinational instruction decode to an ALU control code.
  always_comb begin
    dec_code    = '0;
    dec_illegal = 1'b0;
    case (iALUOp)
      2'b00: dec_code = OPADD;
      2'b01: dec_code = OPSUB;
      2'b10: begin
        case (iFunct)
          6'h00:   dec_code = OPSLL;
          6'h02:   dec_code = OPSRL;
          6'h03:   dec_code = OPSRA;
          6'h04:   dec_code = OPSLL;   // SLLV: same ALU op, shift amount from rs
          6'h06:   dec_code = OPSRL;   // SRLV
          6'h07:   dec_code = OPSRA;   // SRAV
          6'h10:   dec_code = OPMFHI;
          6'h11:   dec_code = OPMTHI;
          6'h12:   dec_code = OPMFLO;
          6'h13:   dec_code = OPMTLO;
          6'h18:   dec_code = OPMULT;
          6'h19:   dec_code = OPMULTU;
          6'h1A:   dec_code = OPDIV;
          6'h1B:   dec_code = OPDIVU;
          6'h20:   dec_code = OPADD;
          6'h21:   dec_code = OPADDU;
          6'h22:   dec_code = OPSUB;
          6'h23:   dec_code = OPSUBU;
          6'h24:   dec_code = OPAND;
          6'h25:   dec_code = OPOR;
          6'h26:   dec_code = OPXOR;
          6'h27:   dec_code = OPNOR;
          6'h2A:   dec_code = OPSLT;
          6'h2B:   dec_code = OPSLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: begin
        case (iOpcode)
          6'h08:   dec_code = OPADD;
          6'h09:   dec_code = OPADDU;
          6'h0A:   dec_code = OPSLT;
          6'h0B:   dec_code = OPSLTU;
          6'h0C:   dec_code = OPAND;
          6'h0D:   dec_code = OPOR;
          6'h0E:   dec_code = OPXOR;
          6'h0F:   dec_code = OPLUI;
          6'h03:   dec_code = OPAND;   // JAL: link path needs a pass-through op
          6'h06, 6'h07: begin          // BLEZ / BGTZ are only valid with rt = 0
            if (iRt == 5'd0) dec_code = OPSGT;
            else             dec_illegal = 1'b1;
          end
          6'h01: begin                 // REGIMM: BLTZ, BGEZ, BLTZAL, BGEZAL
            case (iRt)
              5'h00, 5'h01, 5'h10, 5'h11: dec_code = OPSLT;
              default:                    dec_illegal = 1'b1;
            endcase
          end
`ifdef ALU_SEQ_MADD_EN
          6'h1C: begin                 // SPECIAL2 accumulate ops
            case (iFunct)
              6'h00:   dec_code = OPMADD;
              6'h01:   dec_code = OPMADDU;
              6'h04:   dec_code = OPMSUB;
              6'h05:   dec_code = OPMSUBU;
              default: dec_illegal = 1'b1;
            endcase
          end
`else
          6'h1C:   dec_illegal = 1'b1;
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Classify the decoded op for sequencing and hazard detection.
  always_comb begin
    dec_md = (dec_code == OPMULT) || (dec_code == OPMULTU) ||
             (dec_code == OPDIV)  || (dec_code == OPDIVU)  ||
             (dec_code == OPMADD) || (dec_code == OPMADDU) ||
             (dec_code == OPMSUB) || (dec_code == OPMSUBU);
    dec_hl = (dec_code == OPMFHI) || (dec_code == OPMTHI) ||
             (dec_code == OPMFLO) || (dec_code == OPMTLO);
    dec_div = (dec_code == OPDIV) || (dec_code == OPDIVU);
  end

  // Only HI/LO consumers and new mult/div ops wait for the sequencer.
  assign stall  = (state_reg != IDLE) && (dec_md || dec_hl);
  assign accept = (state_reg == IDLE) && iEnable && !iFlush && dec_md;

  // Sequencer state, counter and output pulse registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      start_reg <= 1'b0;
      hilo_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      start_reg <= start_next;
      hilo_reg  <= hilo_next;
    end
  end

  // Sequencer next-state: IDLE waits for an accept, RUN counts down, DONE commits.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start_next = 1'b0;
    hilo_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          cnt_next   = dec_div ? DIV_LOAD : MULT_LOAD;
          start_next = 1'b1;
        end
      end
      RUN: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          hilo_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered decode: flush inserts a bubble, a stall or disable holds.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ctrl_reg    <= '0;
      illegal_reg <= 1'b0;
    end else if (iFlush) begin
      ctrl_reg    <= '0;
      illegal_reg <= 1'b0;
    end else if (iEnable && !stall) begin
      ctrl_reg    <= dec_code;
      illegal_reg <= dec_illegal;
    end
  end

  assign oControlSignal = ctrl_reg;
  assign oIllegal       = illegal_reg;
  assign oMDStart       = start_reg;
  assign oMDBusy        = (state_reg != IDLE);
  assign oStall         = stall;
  assign oHiLoWrite     = hilo_reg;

endmodule

// File: tb/tb_alu_seq_control.sv
// Directed testbench for alu_seq_control (default parameters).
// Define ALU_SEQ_MADD_EN for both RTL and bench to exercise the SPECIAL2 ops.
module tb_alu_seq_control;

  localparam logic [4:0] C_ADD  = 5'd1;
  localparam logic [4:0] C_SUB  = 5'd3;
  localparam logic [4:0] C_MFHI = 5'd16;
  localparam logic [4:0] C_MULT = 5'd20;
  localparam logic [4:0] C_DIV  = 5'd22;
  localparam logic [4:0] C_MADD = 5'd24;

  logic       clk;
  logic       rst;
  logic       en;
  logic       flush;
  logic [1:0] aluop;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] ctrl;
  logic       illegal;
  logic       mdstart;
  logic       mdbusy;
  logic       stall;
  logic       hilo;

  int total = 0;
  int bad   = 0;

  alu_seq_control dut (
    .iCLK           (clk),
    .iRST           (rst),
    .iEnable        (en),
    .iFlush         (flush),
    .iALUOp         (aluop),
    .iOpcode        (opcode),
    .iFunct         (funct),
    .iRt            (rt),
    .oControlSignal (ctrl),
    .oIllegal       (illegal),
    .oMDStart       (mdstart),
    .oMDBusy        (mdbusy),
    .oStall         (stall),
    .oHiLoWrite     (hilo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present instruction fields and let the combinational stall settle.
  task automatic drive(input logic [1:0] a, input logic [5:0] op,
                       input logic [5:0] fn, input logic [4:0] r);
    aluop  = a;
    opcode = op;
    funct  = fn;
    rt     = r;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    drive(2'b10, 6'h00, 6'h18, 5'd0);
    step(); step();
    total++; if (ctrl !== 5'd0)  begin bad++; $display("FAIL reset_ctrl got=%0d exp=0", ctrl); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    total++; if (mdstart !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", mdstart); end
    total++; if (mdbusy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", mdbusy); end
    total++; if (stall !== 1'b0)   begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (hilo !== 1'b0)    begin bad++; $display("FAIL reset_hilo got=%b exp=0", hilo); end
    $display("txn reset ctrl=%0d ill=%b start=%b busy=%b stall=%b hilo=%b",
             ctrl, illegal, mdstart, mdbusy, stall, hilo);
    rst = 1'b0; en = 1'b0;
    drive(2'b00, 6'h00, 6'h00, 5'd0);
  endtask

  task automatic test_decode();
    logic [1:0] va [13] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11,
                            2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [5:0] vo [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h03,
                            6'h07, 6'h06, 6'h01, 6'h00, 6'h0F, 6'h00};
    logic [5:0] vf [13] = '{6'h20, 6'h00, 6'h00, 6'h27, 6'h2B, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h07};
    logic [4:0] vr [13] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                            5'h00, 5'h01, 5'h11, 5'h00, 5'h00, 5'h00};
    logic [4:0] ec [13] = '{5'd1, 5'd1, 5'd3, 5'd8, 5'd10, 5'd6, 5'd5,
                            5'd15, 5'd0, 5'd9, 5'd0, 5'd14, 5'd13};
    logic       ei [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(va[i], vo[i], vf[i], vr[i]);
      step();
      total++; if (ctrl !== ec[i]) begin bad++; $display("FAIL decode_ctrl[%0d] got=%0d exp=%0d", i, ctrl, ec[i]); end
      total++; if (illegal !== ei[i]) begin bad++; $display("FAIL decode_illegal[%0d] got=%b exp=%b", i, illegal, ei[i]); end
      if (i == 0) begin
        total++; if (stall !== 1'b0)  begin bad++; $display("FAIL add_stall got=%b exp=0", stall); end
        total++; if (mdbusy !== 1'b0) begin bad++; $display("FAIL add_busy got=%b exp=0", mdbusy); end
      end
      $display("txn decode[%0d] aluop=%b op=%h fn=%h rt=%h ctrl=%0d ill=%b",
               i, va[i], vo[i], vf[i], vr[i], ctrl, illegal);
    end
    // Disabled pipeline holds the last capture (SRAV -> 13).
    en = 1'b0;
    drive(2'b01, 6'h00, 6'h00, 5'd0);
    step();
    total++; if (ctrl !== 5'd13) begin bad++; $display("FAIL hold_ctrl got=%0d exp=13", ctrl); end
    $display("txn hold ctrl=%0d", ctrl);
  endtask

  task automatic test_mult();
    en = 1'b1;
    drive(2'b10, 6'h00, 6'h18, 5'd0);
    step();                         // accept edge
    drive(2'b00, 6'h00, 6'h00, 5'd0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) begin
        total++; if (ctrl !== C_MULT) begin bad++; $display("FAIL mult_ctrl got=%0d exp=%0d", ctrl, C_MULT); end
      end
      total++; if (mdstart !== (k == 1)) begin bad++; $display("FAIL mult_start c%0d got=%b exp=%b", k, mdstart, (k == 1)); end
      total++; if (hilo !== (k == 5))    begin bad++; $display("FAIL mult_hilo c%0d got=%b exp=%b", k, hilo, (k == 5)); end
      total++; if (mdbusy !== (k <= 5))  begin bad++; $display("FAIL mult_busy c%0d got=%b exp=%b", k, mdbusy, (k <= 5)); end
      $display("txn mult cycle=%0d start=%b busy=%b hilo=%b", k, mdstart, mdbusy, hilo);
      step();
    end
  endtask

  task automatic test_div_mfhi();
    int n;
    en = 1'b1;
    drive(2'b10, 6'h00, 6'h1A, 5'd0);
    step();                         // DIV accepted
    drive(2'b10, 6'h00, 6'h10, 5'd0);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      step();
    end
    total++; if (n !== 33) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=33", n); end
    total++; if (ctrl !== C_DIV) begin bad++; $display("FAIL div_ctrl_held got=%0d exp=%0d", ctrl, C_DIV); end
    total++; if (mdbusy !== 1'b0) begin bad++; $display("FAIL div_idle got=%b exp=0", mdbusy); end
    step();
    total++; if (ctrl !== C_MFHI) begin bad++; $display("FAIL mfhi_capture got=%0d exp=%0d", ctrl, C_MFHI); end
    $display("txn div_mfhi stall_cycles=%0d ctrl=%0d", n, ctrl);
    drive(2'b00, 6'h00, 6'h00, 5'd0);
    step();
  endtask

  task automatic test_reset_mid();
    int pulses;
    en = 1'b1;
    drive(2'b10, 6'h00, 6'h1A, 5'd0);
    step();                         // DIV accepted
    en = 1'b0;
    drive(2'b10, 6'h00, 6'h10, 5'd0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (mdbusy !== 1'b0)  begin bad++; $display("FAIL rstmid_busy got=%b exp=0", mdbusy); end
    total++; if (ctrl !== 5'd0)    begin bad++; $display("FAIL rstmid_ctrl got=%0d exp=0", ctrl); end
    total++; if (stall !== 1'b0)   begin bad++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
    total++; if (mdstart !== 1'b0) begin bad++; $display("FAIL rstmid_start got=%b exp=0", mdstart); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rstmid_illegal got=%b exp=0", illegal); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (hilo === 1'b1) pulses++;
      step();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_hilo_pulses got=%0d exp=0", pulses); end
    $display("txn reset_mid busy=%b ctrl=%0d hilo_pulses=%0d", mdbusy, ctrl, pulses);
  endtask

  task automatic test_madd();
    int n;
    en = 1'b1;
    drive(2'b11, 6'h1C, 6'h00, 5'd0);
    step();
    drive(2'b00, 6'h00, 6'h00, 5'd0);
`ifdef ALU_SEQ_MADD_EN
    total++; if (ctrl !== C_MADD)  begin bad++; $display("FAIL madd_ctrl got=%0d exp=%0d", ctrl, C_MADD); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL madd_illegal got=%b exp=0", illegal); end
    total++; if (mdstart !== 1'b1) begin bad++; $display("FAIL madd_start got=%b exp=1", mdstart); end
`else
    total++; if (ctrl !== 5'd0)    begin bad++; $display("FAIL madd_ctrl got=%0d exp=0", ctrl); end
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL madd_illegal got=%b exp=1", illegal); end
    total++; if (mdstart !== 1'b0) begin bad++; $display("FAIL madd_start got=%b exp=0", mdstart); end
    total++; if (mdbusy !== 1'b0)  begin bad++; $display("FAIL madd_busy got=%b exp=0", mdbusy); end
`endif
    $display("txn madd ctrl=%0d ill=%b start=%b (madd_code=%0d)", ctrl, illegal, mdstart, C_MADD);
    n = 0;
    while (mdbusy === 1'b1 && n < 20) begin
      n++;
      step();
    end
    total++; if (mdbusy !== 1'b0) begin bad++; $display("FAIL madd_drain got=%b exp=0", mdbusy); end
  endtask

  task automatic test_flush_accept();
    en = 1'b1;
    drive(2'b00, 6'h00, 6'h00, 5'd0);
    step();                         // ctrl = ADD, nonzero before the flush
    flush = 1'b1;
    drive(2'b10, 6'h00, 6'h18, 5'd0);
    step();
    flush = 1'b0; en = 1'b0;
    total++; if (ctrl !== 5'd0)    begin bad++; $display("FAIL flush_ctrl got=%0d exp=0", ctrl); end
    total++; if (mdstart !== 1'b0) begin bad++; $display("FAIL flush_start got=%b exp=0", mdstart); end
    total++; if (mdbusy !== 1'b0)  begin bad++; $display("FAIL flush_busy got=%b exp=0", mdbusy); end
    step();
    total++; if (mdbusy !== 1'b0)  begin bad++; $display("FAIL flush_busy_later got=%b exp=0", mdbusy); end
    $display("txn flush_accept ctrl=%0d start=%b busy=%b", ctrl, mdstart, mdbusy);
  endtask

  task automatic test_flush_inflight();
    int pulses;
    en = 1'b1;
    drive(2'b10, 6'h00, 6'h18, 5'd0);
    step();                         // MULT accepted
    drive(2'b01, 6'h00, 6'h00, 5'd0);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      if (hilo === 1'b1) pulses++;
      if (k == 2) begin
        total++; if (ctrl !== C_SUB) begin bad++; $display("FAIL busy_flow_ctrl got=%0d exp=%0d", ctrl, C_SUB); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL busy_flow_stall got=%b exp=0", stall); end
        total++; if (mdbusy !== 1'b1) begin bad++; $display("FAIL busy_flow_busy got=%b exp=1", mdbusy); end
        flush = 1'b1;
      end
      if (k == 3) begin
        total++; if (ctrl !== 5'd0) begin bad++; $display("FAIL inflight_flush_ctrl got=%0d exp=0", ctrl); end
      end
      if (k == 5) begin
        total++; if (hilo !== 1'b1) begin bad++; $display("FAIL inflight_hilo got=%b exp=1", hilo); end
      end
      if (k == 7) flush = 1'b0;
      $display("txn inflight cycle=%0d ctrl=%0d busy=%b hilo=%b flush=%b", k, ctrl, mdbusy, hilo, flush);
      step();
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL inflight_hilo_pulses got=%0d exp=1", pulses); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0;
    aluop = 2'b00; opcode = 6'h00; funct = 6'h00; rt = 5'd0;
    test_reset();
    test_decode();
    test_mult();
    test_div_mfhi();
    test_reset_mid();
    test_madd();
    test_flush_accept();
    test_flush_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
